// File: rtl/dbus_responder_pkg.sv
// dbus_responder shared types and constants.
// Timer register map and byte-lane merge helper.
package dbus_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [15:0] MMIO_HI_DEF = 16'h1FAF;
  localparam logic [31:0] CMP_RST     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    R_COUNT   = 2'd0,
    R_COMPARE = 2'd1,
    R_STATUS  = 2'd2,
    R_CTRL    = 2'd3
  } reg_e;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// Core data bus: request from the core, registered read data back.
// No handshake beyond en; every request completes.
interface dbus_if;
  import dbus_responder_pkg::*;

  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [BE_W-1:0]   wen;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output en, addr, wen, wdata,
    input  rdata
  );

  modport slave (
    input  en, addr, wen, wdata,
    output rdata
  );
endinterface

// File: rtl/dbus_responder_byte_ram.sv
// Byte-writable single-port RAM, read-first, registered output.
// No reset so synthesis can map it onto block RAM.
module byte_ram
  import dbus_responder_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [BE_W-1:0]   we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Data bus responder: data RAM plus memory-mapped timer.
// Reads are one cycle, read-first, held until the next access.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int          RAM_AW   = 12,
  parameter logic [15:0] MMIO_HI  = MMIO_HI_DEF,
  parameter logic [31:0] CTRL_RST = 32'h1
) (
  input  logic clk,
  input  logic rst,
  dbus_if.slave dbus,
  output logic timer_irq
);

  logic        is_mmio;
  logic        reg_hit;
  logic        acc_mmio;
  logic        acc_ram;
  reg_e        off;

  logic        sel_count;
  logic        sel_compare;
  logic        sel_status;
  logic        sel_ctrl;

  logic [31:0] count_q, count_d;
  logic [31:0] count_inc;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;
  logic        ctrl_q, ctrl_d;
  logic [31:0] mrd_q, mrd_d;
  logic [31:0] mmio_rd;
  logic        sel_ram_q, sel_ram_d;
  logic        match;
  logic        clr;
  logic [31:0] ram_rdata;
  logic        unused_ok;

  assign is_mmio  = dbus.addr[31:16] == MMIO_HI;
  assign reg_hit  = dbus.addr[15:4] == 12'h000;
  assign off      = reg_e'(dbus.addr[3:2]);
  assign acc_mmio = dbus.en & is_mmio;
  // Gate with reset so a request pending at reset is dropped.
  assign acc_ram  = dbus.en & ~is_mmio & rst;
  assign unused_ok = ^dbus.addr[1:0];

  byte_ram #(
    .AW (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .en_i    (acc_ram),
    .we_i    (dbus.wen),
    .addr_i  (dbus.addr[RAM_AW+1:2]),
    .wdata_i (dbus.wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    sel_count   = 1'b0;
    sel_compare = 1'b0;
    sel_status  = 1'b0;
    sel_ctrl    = 1'b0;
    mmio_rd     = '0;
    if (reg_hit) begin
      unique case (off)
        R_COUNT:   mmio_rd = count_q;
        R_COMPARE: mmio_rd = compare_q;
        R_STATUS:  mmio_rd = {31'b0, pend_q};
        R_CTRL:    mmio_rd = {31'b0, ctrl_q};
      endcase
      if (acc_mmio) begin
        unique case (off)
          R_COUNT:   sel_count   = 1'b1;
          R_COMPARE: sel_compare = 1'b1;
          R_STATUS:  sel_status  = 1'b1;
          R_CTRL:    sel_ctrl    = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    count_inc = count_q + {31'b0, ctrl_q};
    count_d   = count_inc;
    if (sel_count) begin
      count_d = merge_bytes(count_inc, dbus.wdata, dbus.wen);
    end
    compare_d = compare_q;
    if (sel_compare) begin
      compare_d = merge_bytes(compare_q, dbus.wdata, dbus.wen);
    end
    match  = ctrl_q & (count_q == compare_q);
    clr    = sel_status & dbus.wen[0] & dbus.wdata[0];
    // A match in the same cycle as a clear keeps pend set.
    pend_d = match | (pend_q & ~clr);
    ctrl_d = ctrl_q;
    if (sel_ctrl && dbus.wen[0]) begin
      ctrl_d = dbus.wdata[0];
    end
    mrd_d     = acc_mmio ? mmio_rd : mrd_q;
    sel_ram_d = dbus.en ? ~is_mmio : sel_ram_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      compare_q <= CMP_RST;
      pend_q    <= 1'b0;
      ctrl_q    <= CTRL_RST[0];
      mrd_q     <= '0;
      sel_ram_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
      ctrl_q    <= ctrl_d;
      mrd_q     <= mrd_d;
      sel_ram_q <= sel_ram_d;
    end
  end

  assign dbus.rdata = sel_ram_q ? ram_rdata : mrd_q;
  assign timer_irq  = pend_q;

endmodule
